// File: rtl/pulse_interval_monitor.sv
// ============================================================================
// Module      : pulse_interval_monitor
// Description : Pulse statistics collector. Over a software-set window of
//               clk cycles it counts single-cycle pulses from the pulse
//               generator and measures pulse-to-pulse intervals (last, min,
//               max). Results stay frozen for readout until the next start
//               or clear.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   clock
//   rst_n          in   asynchronous active-low reset
//   pulse_in       in   pulse stream, one event per high cycle
//   start          in   begin a window (accepted in IDLE or DONE)
//   clear          in   synchronous abort to IDLE, highest priority
//   window_len     in   [WW] window length in cycles, 0 treated as 1
//   busy           out  measurement window in progress
//   done           out  results valid and frozen
//   pulse_count    out  [CW] pulses seen (saturating)
//   last_interval  out  [IW] most recent interval
//   min_interval   out  [IW] smallest interval (all-ones if none)
//   max_interval   out  [IW] largest interval
//   interval_valid out  at least one interval recorded
//   count_sat      out  pulse_count saturated (sticky)
//   interval_sat   out  a recorded interval was clipped (sticky)
// ============================================================================
`default_nettype none

module pulse_interval_monitor #(
  parameter int IW = 16,
  parameter int CW = 16,
  parameter int WW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pulse_in,
  input  logic          start,
  input  logic          clear,
  input  logic [WW-1:0] window_len,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pulse_count,
  output logic [IW-1:0] last_interval,
  output logic [IW-1:0] min_interval,
  output logic [IW-1:0] max_interval,
  output logic          interval_valid,
  output logic          count_sat,
  output logic          interval_sat
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [IW-1:0] C_IV_MAX  = '1;
  localparam logic [CW-1:0] C_CNT_MAX = '1;

  state_t        state_q, state_d;
  logic [WW-1:0] win_len_q, win_len_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  // gap_q is the distance from the previous pulse to the current cycle;
  // gap_ovf_q records that the true distance has gone past C_IV_MAX, so an
  // interval of exactly C_IV_MAX is still reported as unsaturated.
  logic [IW-1:0] gap_q, gap_d;
  logic          gap_ovf_q, gap_ovf_d;
  logic          have_prev_q, have_prev_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] min_q, min_d;
  logic [IW-1:0] max_q, max_d;
  logic          valid_q, valid_d;
  logic          csat_q, csat_d;
  logic          isat_q, isat_d;

  always_comb begin
    state_d     = state_q;
    win_len_d   = win_len_q;
    win_cnt_d   = win_cnt_q;
    gap_d       = gap_q;
    gap_ovf_d   = gap_ovf_q;
    have_prev_d = have_prev_q;
    count_d     = count_q;
    last_d      = last_q;
    min_d       = min_q;
    max_d       = max_q;
    valid_d     = valid_q;
    csat_d      = csat_q;
    isat_d      = isat_q;

    if (clear) begin
      state_d     = S_IDLE;
      win_len_d   = '0;
      win_cnt_d   = '0;
      gap_d       = '0;
      gap_ovf_d   = 1'b0;
      have_prev_d = 1'b0;
      count_d     = '0;
      last_d      = '0;
      min_d       = C_IV_MAX;
      max_d       = '0;
      valid_d     = 1'b0;
      csat_d      = 1'b0;
      isat_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d     = S_MEASURE;
            win_len_d   = (window_len == '0) ? WW'(1) : window_len;
            win_cnt_d   = '0;
            gap_d       = '0;
            gap_ovf_d   = 1'b0;
            have_prev_d = 1'b0;
            count_d     = '0;
            last_d      = '0;
            min_d       = C_IV_MAX;
            max_d       = '0;
            valid_d     = 1'b0;
            csat_d      = 1'b0;
            isat_d      = 1'b0;
          end
        end

        S_MEASURE: begin
          if (pulse_in) begin
            if (count_q == C_CNT_MAX) csat_d = 1'b1;
            else                      count_d = count_q + CW'(1);

            if (have_prev_q) begin
              // gap_q already holds the clipped value when overflowed
              last_d  = gap_q;
              valid_d = 1'b1;
              if (gap_q < min_q) min_d = gap_q;
              if (gap_q > max_q) max_d = gap_q;
              if (gap_ovf_q)     isat_d = 1'b1;
            end
            have_prev_d = 1'b1;
            gap_d       = IW'(1);
            gap_ovf_d   = 1'b0;
          end else begin
            if (gap_q == C_IV_MAX) gap_ovf_d = 1'b1;
            else                   gap_d = gap_q + IW'(1);
          end

          // win_len_q >= 1, so win_len_q - 1 never wraps
          if (win_cnt_q == win_len_q - WW'(1)) state_d = S_DONE;
          else                                 win_cnt_d = win_cnt_q + WW'(1);
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      win_len_q   <= '0;
      win_cnt_q   <= '0;
      gap_q       <= '0;
      gap_ovf_q   <= 1'b0;
      have_prev_q <= 1'b0;
      count_q     <= '0;
      last_q      <= '0;
      min_q       <= C_IV_MAX;
      max_q       <= '0;
      valid_q     <= 1'b0;
      csat_q      <= 1'b0;
      isat_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_len_q   <= win_len_d;
      win_cnt_q   <= win_cnt_d;
      gap_q       <= gap_d;
      gap_ovf_q   <= gap_ovf_d;
      have_prev_q <= have_prev_d;
      count_q     <= count_d;
      last_q      <= last_d;
      min_q       <= min_d;
      max_q       <= max_d;
      valid_q     <= valid_d;
      csat_q      <= csat_d;
      isat_q      <= isat_d;
    end
  end

  assign busy           = (state_q == S_MEASURE);
  assign done           = (state_q == S_DONE);
  assign pulse_count    = count_q;
  assign last_interval  = last_q;
  assign min_interval   = min_q;
  assign max_interval   = max_q;
  assign interval_valid = valid_q;
  assign count_sat      = csat_q;
  assign interval_sat   = isat_q;

endmodule

`default_nettype wire
